// File: rtl/branch_resolve_queue_if.sv
// Fetch/resolve/update bundle for the branch resolve queue.
// The master side drives fetch and resolve; the slave side is the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             fetch_valid;
    logic [63:0]      fetch_pc;
    logic             fetch_pred_taken;
    logic [63:0]      fetch_pred_target;
    logic             fetch_ready;

    logic             resolve_valid;
    logic             resolve_taken;
    logic [63:0]      resolve_target;

    logic             upd_en;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_taken;

    logic             redirect_valid;
    logic [63:0]      redirect_pc;

    logic [CW-1:0]    count;
    logic             underflow_err;

    modport master (
        output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        input  fetch_ready,
        output resolve_valid, resolve_taken, resolve_target,
        input  upd_en, upd_addr, upd_taken,
        input  redirect_valid, redirect_pc,
        input  count, underflow_err
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        output fetch_ready,
        input  resolve_valid, resolve_taken, resolve_target,
        output upd_en, upd_addr, upd_taken,
        output redirect_valid, redirect_pc,
        output count, underflow_err
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the oldest entry,
// trains the predictor and redirects fetch on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    branch_resolve_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN,
        RECOVER
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             upd_en_q, upd_en_d;
    logic [IDX_W-1:0] upd_addr_q, upd_addr_d;
    logic             upd_taken_q, upd_taken_d;
    logic             redir_valid_q, redir_valid_d;
    logic [63:0]      redir_pc_q, redir_pc_d;
    logic             uflow_q, uflow_d;

    logic [63:0]      pc_mem  [DEPTH];
    logic             pt_mem  [DEPTH];
    logic [63:0]      tgt_mem [DEPTH];

    logic [63:0]      head_pc;
    logic             head_pt;
    logic [63:0]      head_tgt;
    logic             ready;
    logic             push;
    logic             pop;
    logic             mispred;

    assign head_pc  = pc_mem[head_q];
    assign head_pt  = pt_mem[head_q];
    assign head_tgt = tgt_mem[head_q];

    assign ready = (state_q == RUN) && (count_q < CW'(DEPTH));
    assign push  = bus.fetch_valid && ready;
    assign pop   = (state_q == RUN) && bus.resolve_valid
                   && (count_q != '0);

    // Target only matters when the branch was actually taken.
    assign mispred = pop
        && ((bus.resolve_taken != head_pt)
            || (bus.resolve_taken
                && (bus.resolve_target != head_tgt)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mispred) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispred) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        upd_en_d      = pop;
        upd_addr_d    = upd_addr_q;
        upd_taken_d   = upd_taken_q;
        redir_valid_d = mispred;
        redir_pc_d    = redir_pc_q;
        uflow_d       = uflow_q;
        if (pop) begin
            upd_addr_d  = head_pc[IDX_W+1:2];
            upd_taken_d = bus.resolve_taken;
        end
        if (mispred) begin
            redir_pc_d = bus.resolve_taken ? bus.resolve_target
                                           : head_pc + 64'd4;
        end
        if (state_q == RUN && bus.resolve_valid && count_q == '0) begin
            uflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= RUN;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_en_q      <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            uflow_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_en_q      <= upd_en_d;
            upd_addr_q    <= upd_addr_d;
            upd_taken_q   <= upd_taken_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            uflow_q       <= uflow_d;
        end
    end

    // Payload storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]  <= bus.fetch_pc;
            pt_mem[tail_q]  <= bus.fetch_pred_taken;
            tgt_mem[tail_q] <= bus.fetch_pred_target;
        end
    end

    assign bus.fetch_ready    = ready;
    assign bus.upd_en         = upd_en_q;
    assign bus.upd_addr       = upd_addr_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.count          = count_q;
    assign bus.underflow_err  = uflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with DEPTH=4, IDX_W=5.
// Expected values are hand-derived from the queue's required behaviour.
module tb_branch_resolve_queue;
    logic clk;
    logic arst_n;
    int   vectors;
    int   errors;

    branch_resolve_queue_if #(.DEPTH(4), .IDX_W(5)) bus ();

    branch_resolve_queue #(.DEPTH(4), .IDX_W(5)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid       = 1'b0;
        bus.fetch_pc          = '0;
        bus.fetch_pred_taken  = 1'b0;
        bus.fetch_pred_target = '0;
        bus.resolve_valid     = 1'b0;
        bus.resolve_taken     = 1'b0;
        bus.resolve_target    = '0;
    endtask

    task automatic set_push(input logic [63:0] pc,
                            input logic pt,
                            input logic [63:0] tgt);
        bus.fetch_valid       = 1'b1;
        bus.fetch_pc          = pc;
        bus.fetch_pred_taken  = pt;
        bus.fetch_pred_target = tgt;
    endtask

    task automatic set_resolve(input logic t, input logic [63:0] tgt);
        bus.resolve_valid  = 1'b1;
        bus.resolve_taken  = t;
        bus.resolve_target = tgt;
    endtask

    task automatic push(input logic [63:0] pc,
                        input logic pt,
                        input logic [63:0] tgt);
        set_push(pc, pt, tgt);
        tick();
        idle();
    endtask

    task automatic resolve(input logic t, input logic [63:0] tgt);
        set_resolve(t, tgt);
        tick();
        idle();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        idle();
        arst_n = 1'b0;
        #2;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_upd_en", 64'(bus.upd_en), 64'd0);
        chk("rst_upd_addr", 64'(bus.upd_addr), 64'd0);
        chk("rst_redir_v", 64'(bus.redirect_valid), 64'd0);
        chk("rst_redir_pc", bus.redirect_pc, 64'd0);
        chk("rst_uflow", 64'(bus.underflow_err), 64'd0);
        #10;
        arst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(bus.fetch_ready), 64'd1);

        // Correctly predicted taken branch
        push(64'h1000, 1'b1, 64'h2000);
        chk("t1_count_push", 64'(bus.count), 64'd1);
        resolve(1'b1, 64'h2000);
        chk("t1_upd_en", 64'(bus.upd_en), 64'd1);
        chk("t1_upd_addr", 64'(bus.upd_addr), 64'h00);
        chk("t1_upd_taken", 64'(bus.upd_taken), 64'd1);
        chk("t1_redir_v", 64'(bus.redirect_valid), 64'd0);
        chk("t1_count", 64'(bus.count), 64'd0);
        tick();
        chk("t1_upd_en_drop", 64'(bus.upd_en), 64'd0);
        chk("t1_upd_addr_hold", 64'(bus.upd_addr), 64'h00);

        // Direction mispredict, taken to 0x3000
        push(64'h1004, 1'b0, 64'h0);
        resolve(1'b1, 64'h3000);
        chk("t2_upd_addr", 64'(bus.upd_addr), 64'h01);
        chk("t2_redir_v", 64'(bus.redirect_valid), 64'd1);
        chk("t2_redir_pc", bus.redirect_pc, 64'h3000);
        chk("t2_ready_low", 64'(bus.fetch_ready), 64'd0);
        tick();
        chk("t2_redir_drop", 64'(bus.redirect_valid), 64'd0);
        chk("t2_ready_back", 64'(bus.fetch_ready), 64'd1);
        chk("t2_redir_hold", bus.redirect_pc, 64'h3000);

        // Fill, overflow drop, push+pop while full
        push(64'h104, 1'b0, 64'h0);
        push(64'h108, 1'b0, 64'h0);
        push(64'h10c, 1'b0, 64'h0);
        push(64'h110, 1'b0, 64'h0);
        chk("t3_full_count", 64'(bus.count), 64'd4);
        chk("t3_full_ready", 64'(bus.fetch_ready), 64'd0);
        push(64'h114, 1'b0, 64'h0);
        chk("t3_drop_count", 64'(bus.count), 64'd4);
        set_push(64'h118, 1'b0, 64'h0);
        set_resolve(1'b0, 64'h0);
        tick();
        idle();
        chk("t3_pp_count", 64'(bus.count), 64'd3);
        chk("t3_pp_addr", 64'(bus.upd_addr), 64'h01);
        resolve(1'b0, 64'h0);
        chk("t3_ord1", 64'(bus.upd_addr), 64'h02);
        resolve(1'b0, 64'h0);
        chk("t3_ord2", 64'(bus.upd_addr), 64'h03);
        resolve(1'b0, 64'h0);
        chk("t3_ord3", 64'(bus.upd_addr), 64'h04);
        chk("t3_empty", 64'(bus.count), 64'd0);

        // Predicted taken, actually not taken, with same-cycle push
        push(64'h40, 1'b1, 64'h80);
        push(64'h50, 1'b0, 64'h0);
        push(64'h60, 1'b0, 64'h0);
        chk("t4_count3", 64'(bus.count), 64'd3);
        set_push(64'h70, 1'b0, 64'h0);
        set_resolve(1'b0, 64'h0);
        tick();
        idle();
        chk("t4_count0", 64'(bus.count), 64'd0);
        chk("t4_redir_v", 64'(bus.redirect_valid), 64'd1);
        chk("t4_redir_pc", bus.redirect_pc, 64'h44);
        chk("t4_upd_addr", 64'(bus.upd_addr), 64'h10);
        chk("t4_upd_taken", 64'(bus.upd_taken), 64'd0);
        set_resolve(1'b0, 64'h0);
        tick();
        idle();
        chk("t4_recover_ign", 64'(bus.underflow_err), 64'd0);
        chk("t4_recover_upd", 64'(bus.upd_en), 64'd0);
        chk("t4_push_dropped", 64'(bus.count), 64'd0);

        // Underflow is sticky and silent
        resolve(1'b1, 64'h0);
        chk("t5_uflow", 64'(bus.underflow_err), 64'd1);
        chk("t5_no_upd", 64'(bus.upd_en), 64'd0);
        chk("t5_no_redir", 64'(bus.redirect_valid), 64'd0);
        tick();
        chk("t5_uflow_sticky", 64'(bus.underflow_err), 64'd1);

        // Pointer wrap with two entries resident
        push(64'h200, 1'b0, 64'h0);
        push(64'h204, 1'b0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            set_push(64'h208 + 64'(4 * i), 1'b0, 64'h0);
            set_resolve(1'b0, 64'h0);
            tick();
            idle();
            chk("t5_wrap_addr", 64'(bus.upd_addr), 64'(i));
            chk("t5_wrap_count", 64'(bus.count), 64'd2);
        end
        resolve(1'b0, 64'h0);
        chk("t5_drain0", 64'(bus.upd_addr), 64'd8);
        resolve(1'b0, 64'h0);
        chk("t5_drain1", 64'(bus.upd_addr), 64'd9);
        chk("t5_drained", 64'(bus.count), 64'd0);

        // Async reset with entries resident
        push(64'h300, 1'b0, 64'h0);
        push(64'h304, 1'b0, 64'h0);
        chk("t6_count2", 64'(bus.count), 64'd2);
        arst_n = 1'b0;
        #1;
        chk("t6_async_count", 64'(bus.count), 64'd0);
        chk("t6_async_uflow", 64'(bus.underflow_err), 64'd0);
        #2;
        arst_n = 1'b1;
        tick();

        // Async reset aborts a pending redirect
        push(64'h300, 1'b0, 64'h0);
        push(64'h304, 1'b0, 64'h0);
        resolve(1'b1, 64'h500);
        chk("t6_redir_pend", 64'(bus.redirect_valid), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("t6_async_redir", 64'(bus.redirect_valid), 64'd0);
        chk("t6_async_rpc", bus.redirect_pc, 64'd0);
        chk("t6_async_cnt2", 64'(bus.count), 64'd0);
        #2;
        arst_n = 1'b1;
        tick();
        chk("t6_ready", 64'(bus.fetch_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of in-flight branch entries (power of two, 2..16).
REQ-002 The block SHALL have parameter IDX_W, default 5, giving the predictor index width.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_valid  input  1  fetch stage presents a predicted branch.
REQ-006 fetch_pc  input  64  PC of the fetched branch.
REQ-007 fetch_pred_taken  input  1  predictor direction for fetch_pc.
REQ-008 fetch_pred_target  input  64  predicted target, meaningful only when fetch_pred_taken=1.
REQ-009 fetch_ready  output  1  queue accepts a push this cycle.
REQ-010 resolve_valid  input  1  execute stage resolves the oldest branch.
REQ-011 resolve_taken  input  1  actual direction.
REQ-012 resolve_target  input  64  actual taken target.
REQ-013 upd_en  output  1  predictor update strobe.
REQ-014 upd_addr  output  IDX_W  predictor write index.
REQ-015 upd_taken  output  1  actual direction sent to the predictor.
REQ-016 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-017 redirect_pc  output  64  corrected fetch PC.
REQ-018 count  output  clog2(DEPTH)+1  current occupancy.
REQ-019 underflow_err  output  1  sticky: resolve_valid seen while empty.

Function
REQ-020 Entries SHALL be held in an in-order circular FIFO (head/tail pointers wrapping modulo DEPTH) storing pc, pred_taken, pred_target.
REQ-021 fetch_ready SHALL be combinational: 1 when state=RUN and count<DEPTH, else 0.
REQ-022 A push SHALL occur when fetch_valid=1 and fetch_ready=1; fetch_valid with fetch_ready=0 SHALL be dropped, not stalled internally.
REQ-023 A pop SHALL occur when resolve_valid=1 and count>0; it compares against the head entry only.
REQ-024 Mispredict SHALL be: resolve_taken!=pred_taken, or resolve_taken=1 and resolve_target!=pred_target.
REQ-025 One cycle after every pop, upd_en SHALL be 1 for exactly one cycle with upd_addr=head pc[IDX_W+1:2] and upd_taken=resolve_taken.
REQ-026 On a mispredicting pop, one cycle later redirect_valid SHALL pulse for one cycle with redirect_pc=resolve_target if resolve_taken=1, else head pc+4 (64-bit wrap).
REQ-027 On a mispredicting pop, all entries SHALL be discarded (count=0, head=tail) at that edge, and any same-cycle push SHALL be dropped.
REQ-028 Simultaneous push and non-mispredicting pop SHALL leave count unchanged; push into a full queue is impossible because fetch_ready=0, even with a same-cycle pop.
REQ-029 FSM states SHALL be RUN and RECOVER: RUN->RECOVER on a mispredicting pop; RECOVER->RUN after exactly one cycle; in RECOVER, fetch_ready=0 and resolve_valid SHALL be ignored.
REQ-030 resolve_valid with count=0 in RUN SHALL set underflow_err, cause no update, and cause no redirect.
REQ-031 redirect_valid and upd_en outputs SHALL be registered; redirect_pc and upd_addr/upd_taken SHALL hold their last values when strobes are 0.

Reset
REQ-032 While arst_n=0: state=RUN, count=0, pointers=0, upd_en=0, upd_addr=0, upd_taken=0, redirect_valid=0, redirect_pc=0, underflow_err=0.
REQ-033 fetch_ready SHALL be 1 from the first cycle after arst_n deasserts; reset asserted mid-operation SHALL discard all entries and abort any pending pulse immediately.

Verification
REQ-034 Push pc=0x1000 pred_taken=1 target=0x2000; resolve taken target=0x2000 -> next cycle upd_en=1, upd_addr=0x00, upd_taken=1, redirect_valid=0, count=0.
REQ-035 Push pc=0x1004 pred_taken=0; resolve taken target=0x3000 -> next cycle upd_addr=0x01, redirect_valid=1, redirect_pc=0x3000; fetch_ready=0 for exactly one cycle.
REQ-036 Push 4 entries -> count=4, fetch_ready=0; 5th fetch_valid dropped; same-cycle push+pop while full -> push dropped, count=3.
REQ-037 Fill 3 entries, mispredict head (pred taken, actual not-taken, pc=0x40) -> redirect_pc=0x44, count=0, same-cycle push dropped.
REQ-038 resolve_valid with empty queue -> underflow_err=1 and stays 1, upd_en=0; run 2*DEPTH pushes/pops -> pointer wrap, order preserved.
REQ-039 Assert arst_n=0 with 2 entries and a pending redirect -> count=0, redirect_valid=0 asynchronously.
